// File: rtl/sha256_core.sv
// SHA-256 single-block compression engine: one round per clock, caller supplies
// pre-padded 512-bit blocks; init restarts from the IV, next chains on current H.
module sha256_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  typedef enum logic [1:0] {CTRL_IDLE, CTRL_ROUNDS, CTRL_DONE} ctrl_e;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  ctrl_e       sha256_ctrl_reg, sha256_ctrl_new;
  logic [31:0] H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg;
  logic [31:0] a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg;
  logic [31:0] a_new, b_new, c_new, d_new, e_new, f_new, g_new, h_new;
  logic [31:0] w_mem [16];
  logic [31:0] w_data, w_next, k_data, t1, t2;
  logic [5:0]  t_ctr_reg;
  logic        ready_flag, valid_flag;
  logic        digest_init, digest_update, state_init, state_update, first_block;
  logic        w_init, w_shift, t_ctr_inc, t_ctr_rst;
  logic        ready_set, ready_clr;

  assign ready        = ready_flag;
  assign digest_valid = valid_flag;
  assign digest       = {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg};

  // The window always holds W[t..t+15], so W[t] is at slot 0 and W[t+16] is shifted in.
  assign w_data = w_mem[0];
  assign w_next = ssig1(w_mem[14]) + w_mem[9] + ssig0(w_mem[1]) + w_mem[0];
  assign k_data = K[t_ctr_reg];

  assign t1 = h_reg + bsig1(e_reg) + ((e_reg & f_reg) ^ (~e_reg & g_reg)) + k_data + w_data;
  assign t2 = bsig0(a_reg) + ((a_reg & b_reg) ^ (a_reg & c_reg) ^ (b_reg & c_reg));

  assign a_new = t1 + t2;
  assign b_new = a_reg;
  assign c_new = b_reg;
  assign d_new = c_reg;
  assign e_new = d_reg + t1;
  assign f_new = e_reg;
  assign g_new = f_reg;
  assign h_new = g_reg;

  always_comb begin
    sha256_ctrl_new = sha256_ctrl_reg;
    digest_init     = 1'b0;
    digest_update   = 1'b0;
    state_init      = 1'b0;
    state_update    = 1'b0;
    first_block     = 1'b0;
    w_init          = 1'b0;
    w_shift         = 1'b0;
    t_ctr_inc       = 1'b0;
    t_ctr_rst       = 1'b0;
    ready_set       = 1'b0;
    ready_clr       = 1'b0;
    unique case (sha256_ctrl_reg)
      CTRL_IDLE: begin
        if (init || next) begin
          first_block     = init;
          digest_init     = init;
          state_init      = 1'b1;
          w_init          = 1'b1;
          t_ctr_rst       = 1'b1;
          ready_clr       = 1'b1;
          sha256_ctrl_new = CTRL_ROUNDS;
        end
      end
      CTRL_ROUNDS: begin
        state_update = 1'b1;
        w_shift      = 1'b1;
        t_ctr_inc    = 1'b1;
        if (t_ctr_reg == 6'd63) sha256_ctrl_new = CTRL_DONE;
      end
      CTRL_DONE: begin
        digest_update   = 1'b1;
        ready_set       = 1'b1;
        sha256_ctrl_new = CTRL_IDLE;
      end
      default: sha256_ctrl_new = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sha256_ctrl_reg <= CTRL_IDLE;
      t_ctr_reg       <= '0;
      ready_flag      <= 1'b1;
      valid_flag      <= 1'b0;
    end else begin
      sha256_ctrl_reg <= sha256_ctrl_new;
      if (t_ctr_rst)      t_ctr_reg <= '0;
      else if (t_ctr_inc) t_ctr_reg <= t_ctr_reg + 6'd1;
      if (ready_clr) begin
        ready_flag <= 1'b0;
        valid_flag <= 1'b0;
      end else if (ready_set) begin
        ready_flag <= 1'b1;
        valid_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg} <= '0;
    end else if (digest_init) begin
      {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg} <= IV;
    end else if (digest_update) begin
      H0_reg <= H0_reg + a_reg;
      H1_reg <= H1_reg + b_reg;
      H2_reg <= H2_reg + c_reg;
      H3_reg <= H3_reg + d_reg;
      H4_reg <= H4_reg + e_reg;
      H5_reg <= H5_reg + f_reg;
      H6_reg <= H6_reg + g_reg;
      H7_reg <= H7_reg + h_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg} <= '0;
    end else if (state_init) begin
      // init loads the IV directly since H is being loaded in the same edge
      if (first_block)
        {a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg} <= IV;
      else
        {a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg} <=
          {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg};
    end else if (state_update) begin
      {a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg} <=
        {a_new, b_new, c_new, d_new, e_new, f_new, g_new, h_new};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) w_mem[i] <= '0;
    end else if (w_init) begin
      for (int i = 0; i < 16; i++) w_mem[i] <= block[511 - 32*i -: 32];
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) w_mem[i] <= w_mem[i+1];
      w_mem[15] <= w_next;
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core using FIPS 180-4 example vectors.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init = 1'b0;
  logic         next = 1'b0;
  logic [511:0] block = '0;
  logic         ready;
  logic [255:0] digest;
  logic         digest_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_DIG1 =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_DIG2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_core dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .next         (next),
    .block        (block),
    .ready        (ready),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse init or next for one cycle and confirm the core went busy after E0.
  task automatic start_blk(input string tag, input logic is_init, input logic [511:0] blk);
    @(negedge clk);
    init  = is_init;
    next  = ~is_init;
    block = blk;
    @(posedge clk);
    #1;
    e0   = cyc;
    init = 1'b0;
    next = 1'b0;
    check({tag, "_busy"}, {255'h0, ready}, 256'h0);
  endtask

  // Bounded wait for ready; checks latency, valid flag and digest.
  task automatic wait_done(input string tag, input logic [255:0] exp);
    while (!ready && (cyc - e0) < 200) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_ready"}, {255'h0, ready}, 256'h1);
    check({tag, "_latency"}, 256'(cyc - e0), 256'd65);
    check({tag, "_valid"}, {255'h0, digest_valid}, 256'h1);
    check({tag, "_digest"}, digest, exp);
  endtask

  initial begin
    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {255'h0, ready}, 256'h1);
    check("rst_valid", {255'h0, digest_valid}, 256'h0);
    check("rst_digest", digest, 256'h0);
    @(negedge clk);
    reset_n = 1'b1;

    start_blk("abc", 1'b1, ABC_BLK);
    wait_done("abc", ABC_DIG);

    // digest holds while idle
    repeat (10) @(posedge clk);
    #1;
    check("abc_hold", digest, ABC_DIG);
    check("abc_hold_valid", {255'h0, digest_valid}, 256'h1);

    start_blk("two1", 1'b1, TWO_BLK1);
    wait_done("two1", TWO_DIG1);
    start_blk("two2", 1'b0, TWO_BLK2);
    wait_done("two2", TWO_DIG2);

    // init/next/block disturbed mid-rounds must not affect the result
    start_blk("intf", 1'b1, ABC_BLK);
    repeat (5) @(posedge clk);
    @(negedge clk);
    init  = 1'b1;
    next  = 1'b1;
    block = {16{32'hdeadbeef}};
    repeat (3) @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    next = 1'b0;
    wait_done("intf", ABC_DIG);

    // asynchronous reset in the middle of the rounds
    start_blk("mid", 1'b1, TWO_BLK1);
    while ((cyc - e0) < 30) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {255'h0, ready}, 256'h1);
    check("mid_rst_valid", {255'h0, digest_valid}, 256'h0);
    check("mid_rst_digest", digest, 256'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_blk("post", 1'b1, ABC_BLK);
    wait_done("post", ABC_DIG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
